// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider gated by a debounced
// PLL/DCM lock. Each channel has a period N, a high time H and a start count P.
// New config is staged in pending registers and moves to the active set only
// at a safe point: the end of a period, while the channel is stopped, or on sync.
module clk_div_gen #(
    parameter int NCH       = 4,
    parameter int CH_W      = 2,
    parameter int DIV_W     = 16,
    parameter int LOCK_WAIT = 16,
    parameter int DEF_DIV   = 2,
    parameter int DEF_HIGH  = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             lock_in,
    input  logic [NCH-1:0]   ch_en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             ready,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   cfg_pend
);

    localparam int              LW_W   = $clog2(LOCK_WAIT + 1);
    localparam logic [LW_W-1:0] LW_MAX = LW_W'(LOCK_WAIT);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEF_HIGH);

    // lock path
    logic            lock_s1_q, lock_s_q;
    logic [LW_W-1:0] lock_cnt_q, lock_cnt_d;

    // per-channel state
    logic [DIV_W-1:0] cnt_q   [NCH];
    logic [DIV_W-1:0] cnt_d   [NCH];
    logic [DIV_W-1:0] div_q   [NCH];
    logic [DIV_W-1:0] div_d   [NCH];
    logic [DIV_W-1:0] high_q  [NCH];
    logic [DIV_W-1:0] high_d  [NCH];
    logic [DIV_W-1:0] phase_q [NCH];
    logic [DIV_W-1:0] phase_d [NCH];
    logic [DIV_W-1:0] pdiv_q  [NCH];
    logic [DIV_W-1:0] pdiv_d  [NCH];
    logic [DIV_W-1:0] phigh_q [NCH];
    logic [DIV_W-1:0] phigh_d [NCH];
    logic [DIV_W-1:0] pphase_q[NCH];
    logic [DIV_W-1:0] pphase_d[NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   clk_q, clk_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   run_prev_q, run_prev_d;

    // combinational helpers
    logic [DIV_W-1:0] src_div  [NCH];
    logic [DIV_W-1:0] src_high [NCH];
    logic [DIV_W-1:0] src_phase[NCH];
    logic [DIV_W-1:0] n_c      [NCH];
    logic [DIV_W-1:0] h_c      [NCH];
    logic [DIV_W-1:0] p_c      [NCH];
    logic [DIV_W-1:0] eff_p    [NCH];
    logic [NCH-1:0]   run, wrap, we_hit, apply_evt, do_apply;

    // ready is qualified by the synchronised lock so it drops the same cycle lock_s does
    assign ready    = lock_s_q & (lock_cnt_q == LW_MAX);
    assign clk_out  = clk_q & {NCH{ready}};
    assign tick     = tick_q & {NCH{ready}};
    assign cfg_pend = pend_q;

    // settle counter: saturating count of consecutive lock_s cycles
    always_comb begin
        lock_cnt_d = '0;
        if (lock_s_q) begin
            lock_cnt_d = (lock_cnt_q == LW_MAX) ? lock_cnt_q : lock_cnt_q + LW_W'(1);
        end
    end

    // per-channel config staging, clamping, counting and output generation
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            run[i]       = ready & ch_en[i];
            wrap[i]      = (cnt_q[i] == div_q[i] - ONE);
            we_hit[i]    = cfg_we && (cfg_ch == CH_W'(i));
            apply_evt[i] = sync | ~run[i] | wrap[i];
            do_apply[i]  = apply_evt[i] & (pend_q[i] | we_hit[i]);

            // a write landing on an apply cycle goes straight through
            src_div[i]   = we_hit[i] ? cfg_div   : pdiv_q[i];
            src_high[i]  = we_hit[i] ? cfg_high  : phigh_q[i];
            src_phase[i] = we_hit[i] ? cfg_phase : pphase_q[i];

            n_c[i] = (src_div[i] < TWO) ? TWO : src_div[i];
            if (src_high[i] == '0)
                h_c[i] = ONE;
            else if (src_high[i] >= n_c[i])
                h_c[i] = n_c[i] - ONE;
            else
                h_c[i] = src_high[i];
            p_c[i] = (src_phase[i] >= n_c[i]) ? '0 : src_phase[i];

            pdiv_d[i]   = we_hit[i] ? cfg_div   : pdiv_q[i];
            phigh_d[i]  = we_hit[i] ? cfg_high  : phigh_q[i];
            pphase_d[i] = we_hit[i] ? cfg_phase : pphase_q[i];
            pend_d[i]   = (pend_q[i] | we_hit[i]) & ~apply_evt[i];

            div_d[i]   = do_apply[i] ? n_c[i] : div_q[i];
            high_d[i]  = do_apply[i] ? h_c[i] : high_q[i];
            phase_d[i] = do_apply[i] ? p_c[i] : phase_q[i];
            eff_p[i]   = do_apply[i] ? p_c[i] : phase_q[i];

            if (!run[i])
                cnt_d[i] = '0;
            else if (sync || !run_prev_q[i])
                cnt_d[i] = eff_p[i];
            else if (wrap[i])
                cnt_d[i] = '0;
            else
                cnt_d[i] = cnt_q[i] + ONE;

            // the start cycle holds a forced-zero count, so it never drives the output
            clk_d[i]      = run[i] & run_prev_q[i] & (cnt_q[i] < high_q[i]);
            tick_d[i]     = clk_d[i] & ~clk_q[i];
            run_prev_d[i] = run[i];
        end
    end

    // lock synchroniser and settle counter registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1_q  <= 1'b0;
            lock_s_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            lock_s1_q  <= lock_in;
            lock_s_q   <= lock_s1_q;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // channel state registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= DEF_N;
                high_q[i]   <= DEF_H;
                phase_q[i]  <= '0;
                pdiv_q[i]   <= DEF_N;
                phigh_q[i]  <= DEF_H;
                pphase_q[i] <= '0;
            end
            pend_q     <= '0;
            clk_q      <= '0;
            tick_q     <= '0;
            run_prev_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                div_q[i]    <= div_d[i];
                high_q[i]   <= high_d[i];
                phase_q[i]  <= phase_d[i];
                pdiv_q[i]   <= pdiv_d[i];
                phigh_q[i]  <= phigh_d[i];
                pphase_q[i] <= pphase_d[i];
            end
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            run_prev_q <= run_prev_d;
        end
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised multi-channel clock divider. Supersedes fixed-ratio divider logic hard-coded per frequency.
- Derives NCH registered divided clocks plus single-cycle tick strobes from one source clock.
- Each channel has runtime-programmable period, high time and phase.
- Outputs are gated by a debounced PLL/DCM lock indication.
- Sits after the clocking primitives; feeds ADC/DSP/comm timing logic.

Parameters:
- NCH, 4, number of output channels
- CH_W, 2, width of cfg_ch (must satisfy 2^CH_W >= NCH)
- DIV_W, 16, width of divide/high/phase fields
- LOCK_WAIT, 16, consecutive synchronised-lock cycles required before ready
- DEF_DIV, 2, reset period (source cycles) for all channels
- DEF_HIGH, 1, reset high time for all channels

Ports:
- clk_in  input  1  source clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- lock_in  input  1  PLL/DCM lock, asynchronous to clk_in
- ch_en  input  NCH  per-channel run enable
- sync  input  1  one-cycle pulse; realigns all channels
- cfg_we  input  1  config write strobe
- cfg_ch  input  CH_W  target channel index
- cfg_div  input  DIV_W  period N in source cycles
- cfg_high  input  DIV_W  high time H in source cycles
- cfg_phase  input  DIV_W  start count P
- ready  output  1  lock qualified and settled
- clk_out  output  NCH  divided clocks, registered
- tick  output  NCH  one-cycle strobe on each clk_out rising edge
- cfg_pend  output  NCH  pending (unapplied) config per channel

Behaviour:
- Reset values: ready=0, clk_out=0, tick=0, cfg_pend=0, lock synchroniser=0, settle counter=0. Active and pending config per channel: N=DEF_DIV, H=DEF_HIGH, P=0; channel counters=0.
- Lock path:
  - lock_in passes through a 2-flop synchroniser giving lock_s.
  - Settle counter increments while lock_s=1 and saturates at LOCK_WAIT; ready=1 once it reaches LOCK_WAIT.
  - lock_s=0 clears the counter, and ready drops in the same cycle.
  - Latency from a lock_in rise to ready is LOCK_WAIT+2 cycles.
- Channel run condition: run_i = ready & ch_en[i].
  - While run_i=0: cnt_i=0, clk_out[i]=0, tick[i]=0. Pending config still applies immediately (see Config).
  - On a run_i 0->1 transition, cnt_i loads P_i.
- Counting while run_i=1: cnt_i increments and wraps at N_i-1 back to 0.
  - clk_out[i] is registered: it is 1 in the cycle after cnt_i < H_i was true, i.e. one cycle of latency from cnt to output.
  - tick[i] is registered and coincides with the clk_out[i] 0->1 edge (tick=1 exactly when clk_out goes high).
- Clamping, applied when config is loaded into active registers:
  - N < 2 is treated as 2.
  - H = 0 is treated as 1.
  - H >= N is treated as N-1.
  - P >= N is treated as 0.
  - Result: no stuck-at output, and duty is always H/N.
- Config:
  - cfg_we with cfg_ch < NCH writes the pending registers of channel cfg_ch and sets cfg_pend[cfg_ch]. cfg_ch >= NCH is ignored.
  - Pending config is applied, and cfg_pend cleared, on the first of:
    - the cycle cnt_i == N_i-1 while running (glitch-free period boundary; the new period starts at cnt 0), or
    - any cycle with run_i=0, or
    - sync.
  - A second write before apply overwrites pending; only the last write takes effect.
  - cfg_we and an apply event in the same cycle: the written value is the one applied, and cfg_pend ends at 0.
- Sync: when sync=1, every channel takes pending config (if any) and loads cnt_i = clamped P_i.
  - Running channels continue from there; sync has no effect on stopped channels other than config apply.
  - After sync, channels with equal N and P are edge-aligned.
- Lock loss mid-operation: all clk_out and tick go to 0 in the cycle ready falls. Configs are retained.
- Async reset mid-operation: all outputs go to reset values immediately, regardless of clock.

Test Plan:
- Reset, then lock_in held 1 with LOCK_WAIT=16 -> ready rises exactly 18 cycles after the lock_in rise; clk_out stays 0 until then.
- ch_en=4'b0001 with defaults (N=2, H=1) -> clk_out[0] toggles every cycle, tick[0] every 2nd cycle; other channels stay 0.
- Channel 1 written N=5, H=2, P=0 while stopped, then enabled -> period 5, high 2 cycles, tick every 5 cycles; cfg_pend[1] clears on the cycle after the write.
- Channel 1 running at N=5, then write N=8, H=4 mid-period -> cfg_pend[1]=1 until cnt=4; the next period is 8 cycles with no runt pulse.
- Channels 2 and 3 with N=6 and P=0/3 respectively, then a sync pulse -> both restart in the cycle after sync, and channel 3 is 180 degrees ahead; a sync coinciding with a write uses the new value.
- Clamp and boundary checks:
  - Write N=1, H=0, P=9 -> behaves as N=2, H=1, P=0.
  - Write H=7 with N=4 -> H=3.
  - Deassert lock_in mid-run -> ready and all clk_out fall 2 cycles later, and resume from P after re-lock plus settle.
